rtc_adj_slewer: RTL
===================

// Module: rtc_adj_slewer
// PURPOSE
//  Sequences precise-time corrections into the RTC timer's one-shot adjust port (adj_ld/adj_ld_data/period_adj).
//  Accepts one signed offset command and slews it in as clamped per-step period corrections.
//  Spaces adj_ld pulses so each step is consumed before the next is loaded.
//  Sits between the servo/host register block and the RTC timer; drives that port exclusively.
// PARAMETERS
//  MAX_STEP   40'h00_8000_0000  max |correction| per step, 39:32 ns, 31:0 ns_fraction (0.5 ns)
//  ADJ_DELAY  32'd0             adj_ld_data value: cycles from load to apply
//  MIN_GAP    16'd4             cycles from adj_ld to next adj_ld; must be >= ADJ_DELAY+2 (elaboration error otherwise)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, synchronous, active-high
//  cmd_valid     in   1   offset command valid
//  cmd_ready     out  1   high in IDLE only; accept = cmd_valid & cmd_ready
//  cmd_offset    in   48  signed two's-complement offset, 47:32 ns, 31:0 ns_fraction
//  adj_ld        out  1   one-cycle pulse to RTC timer
//  adj_ld_data   out  32  = ADJ_DELAY whenever adj_ld is high, else 0
//  period_adj    out  40  current step, two's complement truncated to 40 bits, held through GAP
//  busy          out  1   high in ISSUE/GAP
//  done          out  1   one-cycle pulse when a command completes (or is aborted)
//  aborted       out  1   qualifies done; 1 = command abandoned with residue
//  remaining     out  48  signed residue not yet issued
//  abort         in   1   present only with RTC_ADJ_ABORT_EN
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; adj_ld=0, adj_ld_data=0, period_adj=0, busy=0, done=0, aborted=0, remaining=0, gap counter=0.
//  Reset has priority over every other input, including mid-command; no further adj_ld after reset.
//  IDLE: on accept with cmd_offset!=0: remaining<=cmd_offset, go to ISSUE.
//    On accept with offset==0: done=1 next cycle, aborted=0, stay in IDLE, no adj_ld.
//  ISSUE (1 cycle):
//    step = remaining clamped to [-MAX_STEP, +MAX_STEP].
//    Registered outputs next cycle: adj_ld=1, adj_ld_data=ADJ_DELAY, period_adj=step[39:0].
//    remaining<=remaining-step; gap counter<=MIN_GAP-1; go to GAP.
//  GAP:
//    adj_ld=0; period_adj held; counter decrements.
//    At 0: if remaining==0, done=1, period_adj<=0, go to IDLE; else go to ISSUE.
//  Timing: adj_ld pulses are exactly MIN_GAP+1 cycles apart.
//    N steps = ceil(|offset|/MAX_STEP); done occurs (N)*(MIN_GAP+1)+1 cycles after accept.
//  Arithmetic: 48-bit signed subtract; a command of exactly -2^47 clamps normally (no overflow, |step|<=MAX_STEP).
//  cmd_valid while busy: ignored (cmd_ready=0), no queueing.
// CONFIGURATION
//  RTC_ADJ_ABORT_EN defined: abort input exists.
//    Any-cycle abort while busy sets sticky abort_pend; the in-flight step completes its GAP.
//    Next GAP end then goes to IDLE with done=1, aborted=1; remaining keeps the residue until the next accept.
//    Abort in IDLE is ignored.
//  Not defined: no abort port, aborted tied 0, abort_pend logic removed.
// STRUCTURE
//  Shared package rtc_pkg: state encoding (IDLE/ISSUE/GAP) and width constants.
//    RTC_NS_FRAC_W=32, RTC_OFFSET_W=48, RTC_PERIOD_W=40.
//  Sub-module rtc_adj_step_clamp: combinational signed clamp of remaining to +/-MAX_STEP.
//  Everything else (FSM, gap counter, output registers) in this module.
// TESTING
//  1. +1.25 ns (48'h0001_4000_0000): three adj_ld with period_adj 40'h00_8000_0000, 40'h00_8000_0000, 40'h00_4000_0000.
//     Pulses 5 cycles apart; done, remaining=0.
//  2. -0.75 ns (48'hFFFF_4000_0000): period_adj 40'hFF_8000_0000 then 40'hFF_C000_0000; done, aborted=0.
//  3. Zero offset: no adj_ld, done one cycle after accept, cmd_ready stays 1.
//  4. cmd_valid held during a busy command: cmd_ready=0, second offset ignored, step count unchanged.
//  5. rst asserted during GAP of step 2 of 3: all outputs at reset values next cycle, no further adj_ld.
//  6. RTC_ADJ_ABORT_EN: +2 ns, abort during step 1: exactly one adj_ld, then done=1, aborted=1, remaining=48'h0001_8000_0000.
//  Closed loop with RTC timer: accumulated time shift equals commanded offset to the fraction LSB.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC adjust slewer: FSM encoding and datapath widths.
package rtc_pkg;

  localparam int RTC_NS_FRAC_W = 32;
  localparam int RTC_OFFSET_W  = 48;
  localparam int RTC_PERIOD_W  = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } rtc_state_e;

endpackage

// File: rtl/rtc_adj_step_clamp.sv
// Combinational signed clamp of the outstanding residue to +/-MAX_STEP.
// The limits are formed at the full offset width, so even -2^47 clamps
// cleanly to -MAX_STEP without overflow.
module rtc_adj_step_clamp
  import rtc_pkg::*;
#(
  parameter logic [RTC_PERIOD_W-1:0] MAX_STEP = 40'h00_8000_0000
) (
  input  logic signed [RTC_OFFSET_W-1:0] remaining,
  output logic signed [RTC_OFFSET_W-1:0] step
);

  localparam logic signed [RTC_OFFSET_W-1:0] POS_LIM =
    signed'({{(RTC_OFFSET_W-RTC_PERIOD_W){1'b0}}, MAX_STEP});
  localparam logic signed [RTC_OFFSET_W-1:0] NEG_LIM = -POS_LIM;

  // Saturate the residue into the per-step window.
  always_comb begin
    step = remaining;
    if (remaining > POS_LIM)      step = POS_LIM;
    else if (remaining < NEG_LIM) step = NEG_LIM;
  end

endmodule

// File: rtl/rtc_adj_slewer.sv
// Slews a signed time-offset command into the RTC timer's one-shot adjust
// port as a train of clamped period corrections, one adj_ld every MIN_GAP+1
// cycles. Optional feature: define RTC_ADJ_ABORT_EN to add the abort input.
module rtc_adj_slewer
  import rtc_pkg::*;
#(
  parameter logic [RTC_PERIOD_W-1:0] MAX_STEP  = 40'h00_8000_0000,
  parameter logic [31:0]             ADJ_DELAY = 32'd0,
  parameter logic [15:0]             MIN_GAP   = 16'd4
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef RTC_ADJ_ABORT_EN
  input  logic                           abort,
`endif
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [RTC_OFFSET_W-1:0]        cmd_offset,
  output logic                           adj_ld,
  output logic [31:0]                    adj_ld_data,
  output logic [RTC_PERIOD_W-1:0]        period_adj,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  output logic [RTC_OFFSET_W-1:0]        remaining
);

  // The timer must have consumed a load before the next one arrives.
  if ({17'd0, MIN_GAP} < {1'b0, ADJ_DELAY} + 33'd2) begin : g_gap_chk
    $error("rtc_adj_slewer: MIN_GAP must be >= ADJ_DELAY+2");
  end

  rtc_state_e                     state, state_nxt;
  logic signed [RTC_OFFSET_W-1:0] rem;
  logic signed [RTC_OFFSET_W-1:0] step;
  logic [15:0]                    cnt;
  logic                           accept, gap_end, abort_now;

  assign accept    = cmd_valid & cmd_ready;
  assign gap_end   = (state == ST_GAP) && (cnt == 16'd0);
  assign remaining = rem;

  rtc_adj_step_clamp #(.MAX_STEP(MAX_STEP)) u_clamp (
    .remaining(rem),
    .step     (step)
  );

`ifdef RTC_ADJ_ABORT_EN
  logic abort_pend;

  // Sticky abort request; cleared once the command retires to IDLE.
  always_ff @(posedge clk) begin
    if (rst)                                 abort_pend <= 1'b0;
    else if (gap_end && state_nxt == ST_IDLE) abort_pend <= 1'b0;
    else if (busy && abort)                  abort_pend <= 1'b1;
  end

  // An abort landing on the final GAP cycle still takes effect there.
  assign abort_now = abort_pend | (busy & abort);
`else
  assign abort_now = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && cmd_offset != '0) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_GAP;
      ST_GAP:   if (gap_end) state_nxt = (rem == '0 || abort_now) ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
  end

  // Registered adjust-port outputs, residue and gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      adj_ld      <= 1'b0;
      adj_ld_data <= '0;
      period_adj  <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      rem         <= '0;
      cnt         <= '0;
    end else begin
      adj_ld      <= 1'b0;
      adj_ld_data <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Any accept replaces a stale residue; a zero offset retires at once.
          if (accept) begin
            rem <= cmd_offset;
            if (cmd_offset == '0) done <= 1'b1;
          end
        end
        ST_ISSUE: begin
          adj_ld      <= 1'b1;
          adj_ld_data <= ADJ_DELAY;
          period_adj  <= step[RTC_PERIOD_W-1:0];
          rem         <= rem - step;
          cnt         <= MIN_GAP - 16'd1;
        end
        ST_GAP: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (rem == '0 || abort_now) begin
            done       <= 1'b1;
            aborted    <= abort_now && (rem != '0);
            period_adj <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
